// File: rtl/var_field_packer_if.sv
// var_field_packer_if: stream bundle between a field producer, the packer and
// a word consumer.
//
// Handshake: a field moves when in_valid && in_ready at a rising clk edge, and
// a word moves when out_valid && out_ready at a rising clk edge. A producer
// holds its payload stable while valid is high and ready is low. Valid never
// waits on ready.
//
// Signals
//   in_valid / in_ready           field handshake
//   in_data [MAX_LEN]             field bits, right-aligned
//   in_len  [$clog2(MAX_LEN+1)]   number of meaningful bits in in_data
//   in_last                       field closes the packet
//   out_valid / out_ready         word handshake
//   out_data [DATA_W]             packed word
//   out_bits [$clog2(DATA_W+1)]   valid bits in out_data
//   out_last                      final word of the packet
// Modports: master = producer/consumer side, slave = packer side.
interface var_field_packer_if #(
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 16
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int BITS_W = $clog2(DATA_W + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [MAX_LEN-1:0]   in_data;
  logic [LEN_W-1:0]     in_len;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [BITS_W-1:0]    out_bits;
  logic                 out_last;

  modport master (
    output in_valid, in_data, in_len, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_bits, out_last
  );

  modport slave (
    input  in_valid, in_data, in_len, in_last, out_ready,
    output in_ready, out_valid, out_data, out_bits, out_last
  );
endinterface

// File: rtl/var_field_packer.sv
// var_field_packer: packs variable-length fields (0..MAX_LEN bits) into
// DATA_W-bit words. LSB-first by default; with MSB_FIRST each field is sent
// MSB first and the first stream bit lands in out_data[DATA_W-1]. A packet
// end flushes leftover bits as a zero-padded partial word.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        var_field_packer_if.slave (field in, word out)
//   dbg_state  current FSM state, 1 = FLUSH, 0 = ACC
module var_field_packer #(
  parameter int DATA_W    = 32,
  parameter int MAX_LEN   = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  var_field_packer_if.slave   bus,
  output logic                dbg_state
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int BITS_W = $clog2(DATA_W + 1);
  localparam int ACC_W  = DATA_W + MAX_LEN;
  localparam int SUM_W  = BITS_W + 1;

  typedef enum logic {ACC = 1'b0, FLUSH = 1'b1} state_t;

  state_t             state;
  logic               started;
  logic [ACC_W-1:0]   acc;
  logic [BITS_W-1:0]  fill;

  logic [MAX_LEN-1:0] masked;
  logic [MAX_LEN-1:0] rev_all;
  logic [MAX_LEN-1:0] field;
  logic [ACC_W-1:0]   acc_ins;
  logic [SUM_W-1:0]   new_fill;
  logic [SUM_W-1:0]   rem_fill;
  logic               slot_free;
  logic               accept;

  // Stream order is built LSB-first in the accumulator; MSB-first output is
  // the mirror image of the same word.
  function automatic logic [DATA_W-1:0] order_word(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = w;
    if (MSB_FIRST) begin
      for (int i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
    end
    return r;
  endfunction

  always_comb begin
    masked  = '0;
    rev_all = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      masked[i] = bus.in_data[i] & (i < int'(bus.in_len));
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      rev_all[i] = masked[MAX_LEN-1-i];
    end
    // Reversing the full MAX_LEN lane parks the field at the top; shifting
    // down by the unused length brings the reversed in_len bits to bit 0.
    if (MSB_FIRST) field = rev_all >> (LEN_W'(MAX_LEN) - bus.in_len);
    else           field = masked;
    // Bits at and above fill are always zero, so OR acts as a write.
    acc_ins  = acc | ({{DATA_W{1'b0}}, field} << fill);
    new_fill = SUM_W'(fill) + SUM_W'(bus.in_len);
    rem_fill = new_fill - SUM_W'(DATA_W);
  end

  assign slot_free    = !bus.out_valid || bus.out_ready;
  // started keeps in_ready low for the first cycle after reset release.
  assign bus.in_ready = started && (state == ACC) && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign dbg_state    = (state == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ACC;
      started       <= 1'b0;
      acc           <= '0;
      fill          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_bits  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      case (state)
        ACC: begin
          if (accept) begin
            if (new_fill >= SUM_W'(DATA_W)) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= order_word(acc_ins[DATA_W-1:0]);
              bus.out_bits  <= BITS_W'(DATA_W);
              acc           <= acc_ins >> DATA_W;
              fill          <= rem_fill[BITS_W-1:0];
              // Leftover bits of a closing field still need their own word.
              if (bus.in_last && rem_fill != '0) begin
                state        <= FLUSH;
                bus.out_last <= 1'b0;
              end else begin
                bus.out_last <= bus.in_last;
              end
            end else if (bus.in_last && new_fill != '0) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= order_word(acc_ins[DATA_W-1:0]);
              bus.out_bits  <= new_fill[BITS_W-1:0];
              bus.out_last  <= 1'b1;
              acc           <= '0;
              fill          <= '0;
            end else begin
              acc  <= acc_ins;
              fill <= new_fill[BITS_W-1:0];
            end
          end
        end
        FLUSH: begin
          if (slot_free) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= order_word(acc[DATA_W-1:0]);
            bus.out_bits  <= fill;
            bus.out_last  <= 1'b1;
            acc           <= '0;
            fill          <= '0;
            state         <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_var_field_packer.sv
// tb_var_field_packer: drives one field stream into an LSB-first and an
// MSB-first packer (DATA_W=8, MAX_LEN=4) and checks both against a bit-queue
// reference model plus directed expected words.
module tb_var_field_packer;
  localparam int DW = 8;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, out_ready;
  logic [ML-1:0] in_data;
  logic [2:0] in_len;
  logic dbg_l, dbg_m;
  bit rand_bp;

  int tests_run = 0;
  int fail_cnt  = 0;

  var_field_packer_if #(.DATA_W(DW), .MAX_LEN(ML)) lif ();
  var_field_packer_if #(.DATA_W(DW), .MAX_LEN(ML)) mif ();

  assign lif.in_valid = in_valid;  assign mif.in_valid = in_valid;
  assign lif.in_data  = in_data;   assign mif.in_data  = in_data;
  assign lif.in_len   = in_len;    assign mif.in_len   = in_len;
  assign lif.in_last  = in_last;   assign mif.in_last  = in_last;
  assign lif.out_ready = out_ready; assign mif.out_ready = out_ready;

  var_field_packer #(.DATA_W(DW), .MAX_LEN(ML), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(lif.slave), .dbg_state(dbg_l));
  var_field_packer #(.DATA_W(DW), .MAX_LEN(ML), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(mif.slave), .dbg_state(dbg_m));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: words packed as {last, bits[3:0], data[7:0]}
  bit          bits_l[$];
  bit          bits_m[$];
  logic [12:0] exp_l[$];
  logic [12:0] exp_m[$];
  logic [12:0] log_l[$];
  logic [12:0] log_m[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: the packet is a plain bit stream; every DW bits make a word,
  // a closing field flushes the rest. MSB mode sends each field MSB first
  // and places stream bit k at word bit DW-1-k.
  function automatic void model_accept(bit msb, int len, logic [ML-1:0] data, bit last);
    bit q[$];
    logic [7:0] w;
    int n;
    if (msb) q = bits_m; else q = bits_l;
    for (int k = 0; k < len; k++) begin
      q.push_back(1'(data >> (msb ? (len - 1 - k) : k)));
    end
    while (q.size() >= DW) begin
      w = '0;
      for (int k = 0; k < DW; k++) w = w | (8'(q.pop_front()) << (msb ? (DW - 1 - k) : k));
      if (msb) exp_m.push_back({last && q.size() == 0, 4'd8, w});
      else     exp_l.push_back({last && q.size() == 0, 4'd8, w});
    end
    if (last && q.size() > 0) begin
      n = q.size();
      w = '0;
      for (int k = 0; k < n; k++) w = w | (8'(q.pop_front()) << (msb ? (DW - 1 - k) : k));
      if (msb) exp_m.push_back({1'b1, 4'(n), w});
      else     exp_l.push_back({1'b1, 4'(n), w});
    end
    if (msb) bits_m = q; else bits_l = q;
  endfunction

  task automatic drain(bit msb, logic [12:0] obs);
    logic [12:0] e;
    if ((msb && exp_m.size() == 0) || (!msb && exp_l.size() == 0)) begin
      tests_run++;
      fail_cnt++;
      $error("FAIL %s_word_unexpected observed=0x%0h expected=none", msb ? "msb" : "lsb", obs);
    end else begin
      if (msb) e = exp_m.pop_front(); else e = exp_l.pop_front();
      check(msb ? "msb_word" : "lsb_word", 32'(obs), 32'(e));
    end
  endtask

  // monitor: transfers happen at the next rising edge, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (lif.out_valid && lif.out_ready) begin
        log_l.push_back({lif.out_last, lif.out_bits, lif.out_data});
        drain(1'b0, {lif.out_last, lif.out_bits, lif.out_data});
      end
      if (mif.out_valid && mif.out_ready) begin
        log_m.push_back({mif.out_last, mif.out_bits, mif.out_data});
        drain(1'b1, {mif.out_last, mif.out_bits, mif.out_data});
      end
      if (lif.in_valid && lif.in_ready) model_accept(1'b0, int'(lif.in_len), lif.in_data, lif.in_last);
      if (mif.in_valid && mif.in_ready) model_accept(1'b1, int'(mif.in_len), mif.in_data, mif.in_last);
    end
  end

  // driver tasks
  int last_wait;

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int len, logic [ML-1:0] data, bit last);
    bit got;
    bit done;
    done = 0;
    last_wait = 0;
    in_valid = 1'b1;
    in_len   = 3'(len);
    in_data  = data;
    in_last  = last;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      got = lif.in_ready;
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      if (got) begin
        done = 1;
        break;
      end
      last_wait++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      tests_run++;
      fail_cnt++;
      $error("FAIL send_timeout observed=no_accept expected=accept");
    end
  endtask

  task automatic clear_model();
    bits_l.delete(); bits_m.delete();
    exp_l.delete();  exp_m.delete();
  endtask

  int cnt0;
  int nf;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_len = '0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; rand_bp = 0;
    idle(2);
    check("rst_out_valid", 32'(lif.out_valid), 0);
    check("rst_out_data", 32'(lif.out_data), 0);
    check("rst_out_bits", 32'(lif.out_bits), 0);
    check("rst_out_last", 32'(lif.out_last), 0);
    check("rst_in_ready", 32'(lif.in_ready), 0);
    check("rst_msb_out_valid", 32'(mif.out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("ready_after_rst", 32'(lif.in_ready), 1);
    check("state_after_rst", 32'(dbg_l), 0);
    idle(1);

    // full word
    cnt0 = log_l.size();
    send(3, 4'b1101, 0); send(4, 4'b1100, 0); send(1, 4'b1111, 0);
    idle(3);
    check("full_count", 32'(log_l.size() - cnt0), 1);
    check("full_lsb", 32'(log_l[log_l.size()-1]), 32'({1'b0, 4'd8, 8'hE5}));
    check("full_msb", 32'(log_m[log_m.size()-1]), 32'({1'b0, 4'd8, 8'hB9}));

    // partial flush
    send(4, 4'b1111, 0); send(3, 4'b1010, 1);
    idle(3);
    check("partial_lsb", 32'(log_l[log_l.size()-1]), 32'({1'b1, 4'd7, 8'h2F}));
    check("partial_msb", 32'(log_m[log_m.size()-1]), 32'({1'b1, 4'd7, 8'hF4}));

    // overflow plus last
    cnt0 = log_l.size();
    send(4, 4'b1010, 0); send(3, 4'b1101, 0); send(4, 4'b0011, 1);
    @(negedge clk);
    check("flush_in_ready", 32'(lif.in_ready), 0);
    check("flush_state", 32'(dbg_l), 1);
    idle(3);
    check("ovf_count", 32'(log_l.size() - cnt0), 2);
    check("ovf_word0", 32'(log_l[log_l.size()-2]), 32'({1'b0, 4'd8, 8'hDA}));
    check("ovf_word1", 32'(log_l[log_l.size()-1]), 32'({1'b1, 4'd3, 8'h01}));

    // backpressure
    out_ready = 1'b0;
    send(4, 4'b0011, 0); send(4, 4'b0101, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(lif.in_ready), 0);
      check("bp_out_valid", 32'(lif.out_valid), 1);
      check("bp_out_data", 32'(lif.out_data), 32'h53);
      check("bp_msb_out_data", 32'(mif.out_data), 32'h35);
      check("bp_out_bits", 32'(lif.out_bits), 8);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4, 4'b1001, 1);
    check("bp_release_wait", 32'(last_wait), 0);
    idle(3);
    check("bp_after_lsb", 32'(log_l[log_l.size()-1]), 32'({1'b1, 4'd4, 8'h09}));

    // single short packet
    send(3, 4'b0101, 1);
    idle(3);
    check("short_msb", 32'(log_m[log_m.size()-1]), 32'({1'b1, 4'd3, 8'hA0}));
    check("short_lsb", 32'(log_l[log_l.size()-1]), 32'({1'b1, 4'd3, 8'h05}));

    // reset while a word is stalled
    out_ready = 1'b0;
    send(3, 4'b0111, 0); send(4, 4'b1111, 0); send(4, 4'b1111, 0);
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    check("rst_stall_out_valid", 32'(lif.out_valid), 0);
    check("rst_stall_msb_valid", 32'(mif.out_valid), 0);
    out_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // reset with fill = 5
    cnt0 = log_l.size();
    send(4, 4'b1111, 0); send(1, 4'b0001, 0);
    idle(2);
    check("fill5_no_word", 32'(log_l.size() - cnt0), 0);
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    check("rst_fill5_valid", 32'(lif.out_valid), 0);
    check("rst_fill5_ready", 32'(lif.in_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
    send(0, 4'b1111, 1);
    idle(4);
    check("len0_last_no_word", 32'(log_l.size() - cnt0), 0);
    send(4, 4'b1001, 1);
    idle(3);
    check("post_rst_lsb", 32'(log_l[log_l.size()-1]), 32'({1'b1, 4'd4, 8'h09}));
    check("post_rst_msb", 32'(log_m[log_m.size()-1]), 32'({1'b1, 4'd4, 8'h90}));

    // random packets under random backpressure
    rand_bp = 1;
    for (int p = 0; p < 40; p++) begin
      nf = $urandom_range(1, 6);
      for (int f = 0; f < nf; f++) begin
        send($urandom_range(0, ML), 4'($urandom), f == nf - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rand_bp = 0;
    out_ready = 1'b1;
    idle(10);
    check("drain_lsb_left", 32'(exp_l.size()), 0);
    check("drain_msb_left", 32'(exp_m.size()), 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule

// File: doc/var_field_packer.md
Name: var_field_packer

Overview:
- Parametrised bit-stream packer. Accepts variable-length fields (0..MAX_LEN bits) on a valid/ready stream.
- Concatenates the fields into DATA_W-bit output words, in LSB-first or MSB-first bit order.
- On packet end, flushes any remaining bits as a zero-padded partial word.
- Sits between header/field generators and fixed-width serialisers.
- Generalises the fixed, constant-offset part-select writes and the streaming reversal into runtime offsets, parametrised widths and a selectable bit order.

Parameters:
- DATA_W, 32, output word width; must be >= MAX_LEN.
- MAX_LEN, 16, maximum field length in bits.
- MSB_FIRST, 0, 0: first bit received goes to out_data[0]; 1: first bit goes to out_data[DATA_W-1], and each field is sent MSB first.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  field present.
- in_ready  output  1  field accepted when in_valid && in_ready.
- in_data  input  MAX_LEN  field bits, right-aligned; bits at and above in_len are ignored.
- in_len  input  $clog2(MAX_LEN+1)  field length, 0..MAX_LEN.
- in_last  input  1  this field ends the packet.
- out_valid  output  1  output word present.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  packed word.
- out_bits  output  $clog2(DATA_W+1)  number of valid bits; DATA_W for full words.
- out_last  output  1  final word of the packet.

Behaviour:
- Reset (async, while rst_n = 0):
  - out_valid = 0, out_data = 0, out_bits = 0, out_last = 0.
  - fill = 0, accumulator = 0, state = ACC.
  - in_ready is combinational and reads 1 one cycle after reset release.
- State: ACC, FLUSH. fill counter range 0..DATA_W-1. Accumulator is DATA_W+MAX_LEN bits wide.
- Output register: a single slot that holds its value while out_valid && !out_ready. out_data, out_bits and out_last stay stable while stalled.
- in_ready = (state == ACC) && (!out_valid || out_ready).
- Accept in ACC:
  - Mask the field to in_len bits. In MSB_FIRST mode, first bit-reverse those in_len bits.
  - OR the field into acc[fill +: MAX_LEN]. new = fill + in_len.
  - If new >= DATA_W:
    - Load acc[DATA_W-1:0] into the output register with out_bits = DATA_W.
    - Shift acc down by DATA_W; fill = new - DATA_W.
    - If in_last and fill > 0: go to FLUSH with out_last = 0.
    - Otherwise out_last = in_last.
  - Else if in_last and new > 0: load a partial word (zero-padded above new bits), out_bits = new, out_last = 1, fill = 0.
  - Else: fill = new, no output.
- FLUSH:
  - When the output slot frees, emit the remainder as a partial word with out_last = 1.
  - Then fill = 0, acc = 0, state = ACC.
  - in_ready = 0 throughout FLUSH.
- MSB_FIRST output: out_data is the bit-reverse (streaming left) of the LSB-first word. A partial word occupies the top out_bits bits; the lower bits are 0.
- in_len = 0: the field is accepted and adds no bits. With in_last and fill = 0, no word is produced.
- out_valid clears on out_ready unless a new word loads in the same cycle; a simultaneous load and drain gives back-to-back words.
- Latency: a word appears in the cycle after the accept that completes it.
- Reset mid-packet discards all partial bits; the next packet starts at fill = 0.

Test Plan (DATA_W=8, MAX_LEN=4 unless noted):
- Full word: fields (len3, 101), (len4, 1100), (len1, 1), out_ready=1 -> one word 0xE5, out_bits=8, out_last=0.
- Partial flush: (len4, 1111), (len3, 010, last) -> 0x2F, out_bits=7, out_last=1.
- Overflow plus last: (4, 1010), (3, 101), (4, 0011, last) -> 0xDA (bits=8, last=0), then 0x01 (bits=3, last=1); in_ready=0 for the FLUSH cycle.
- Backpressure: hold out_ready=0 with out_valid=1 for 5 cycles -> in_ready=0, out_data stable; release -> the word is consumed and the next field is accepted in the same cycle.
- MSB_FIRST=1, same fields as the first scenario -> 0xB9. (len3, 101, last) -> 0xA0, out_bits=3.
- Reset with fill=5 mid-packet -> out_valid=0 immediately. A subsequent (len0, last) produces no word. A subsequent (4, 1001, last) -> 0x09, out_bits=4.
